mem_port_arbiter: RTL and testbench

Arbitrates a single-port unified memory between the instruction-fetch path and the load/store path of the RV32I core. It replaces the separate instruction and data memories with one shared memory port that may take multiple cycles. It sequences every memory transaction through a small FSM and drives a stall to freeze PC and register-file writeback while a requester waits.

---
 rtl/mem_port_arbiter_pkg.sv | 20 ++
 rtl/mem_port_arbiter_if.sv | 52 +++++
 rtl/arb_timeout_counter.sv | 45 ++++
 rtl/mem_port_arbiter.sv | 146 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared types and constants for the unified memory port arbiter.
// Contents:
//   arb_state_t      - arbiter FSM state (idle, fetch busy, data busy)
//   NopInstr         - RV32I NOP (addi x0, x0, 0), returned on an aborted fetch
//   Def*             - default widths and timeout limit
package mem_port_arbiter_pkg;

  localparam int unsigned DefAddrW         = 32;
  localparam int unsigned DefDataW         = 32;
  localparam int unsigned DefTimeoutCycles = 64;

  localparam logic [31:0] NopInstr = 32'h0000_0013;

  typedef enum logic [1:0] {
    StIdle,
    StBusyI,
    StBusyD
  } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: bundles the fetch, load/store and memory-side signals of the arbiter.
// Modports:
//   slave  - the arbiter: takes requests and mem_ready/mem_rdata, drives grants,
//            read data, the memory command, stall and err
//   master - the environment (core fetch + LSU + memory model): the opposite directions
// Signals:
//   if_req/if_addr -> if_gnt/if_rvalid/if_rdata          instruction fetch
//   d_req/d_we/d_addr/d_wdata -> d_gnt/d_rvalid/d_rdata  load/store
//   mem_req/mem_we/mem_addr/mem_wdata <- mem_ready/mem_rdata  shared memory port
//   stall, err                                           pipeline freeze, sticky timeout
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_rdata;

  logic              stall;
  logic              err;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_ready, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata, stall, err
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_ready, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata, stall, err
  );

endinterface

// File: rtl/arb_timeout_counter.sv
// arb_timeout_counter: counts stalled memory cycles and flags when the wait limit is hit.
// Only compiled when MEM_TIMEOUT_EN is defined.
// Ports:
//   clk_i, rst_ni - clock, asynchronous active-low reset
//   clear_i       - restart the count (new transaction granted)
//   enable_i      - count this cycle (busy, memory not ready)
//   limit_i       - number of stalled cycles allowed
//   expired_o     - this counted cycle is the limit-th one; abort now
`ifdef MEM_TIMEOUT_EN
module arb_timeout_counter #(
  parameter int unsigned CntW = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            clear_i,
  input  logic            enable_i,
  input  logic [CntW-1:0] limit_i,
  output logic            expired_o
);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  // Fires in the cycle that would bring the count up to the limit, so the FSM leaves
  // BUSY after exactly limit_i stalled cycles.
  assign expired_o = enable_i && ((cnt_q + CntW'(1)) >= limit_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`endif

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one multi-cycle memory port between instruction fetch and
// load/store. Data requests win over fetch in every grant slot; a grant slot is IDLE or the
// completing cycle of a BUSY state, so transactions can run back to back.
// Ports:
//   clk_i   - clock, all state on the rising edge
//   rst_ni  - asynchronous active-low reset; drops mem_req at once and discards the transaction
//   bus_io  - mem_port_arbiter_if.slave: fetch, load/store and memory port signals, stall, err
// Optional feature: define MEM_TIMEOUT_EN to abort a transaction after TIMEOUT_CYCLES stalled
// cycles (sticky err, fetch returns NOP, load returns 0). Without it err is always 0 and the
// FSM waits forever for mem_ready.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W         = DefAddrW,
  parameter int unsigned DATA_W         = DefDataW,
  parameter int unsigned TIMEOUT_CYCLES = DefTimeoutCycles
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  mem_port_arbiter_if.slave bus_io
);

  arb_state_t        state_q, state_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_we_q, mem_we_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              if_rvalid_q, if_rvalid_d;
  logic              d_rvalid_q, d_rvalid_d;
  logic              err_q, err_d;

  logic busy, done, abort, grant_slot, gnt_d, gnt_i;

  assign busy       = (state_q != StIdle);
  assign done       = busy & bus_io.mem_ready;
  assign grant_slot = ~busy | done;
  assign gnt_d      = grant_slot & bus_io.d_req;
  assign gnt_i      = grant_slot & bus_io.if_req & ~bus_io.d_req;

`ifdef MEM_TIMEOUT_EN
  logic expired;

  arb_timeout_counter #(
    .CntW(32)
  ) u_timeout (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .clear_i  (gnt_d | gnt_i),
    .enable_i (busy & ~bus_io.mem_ready),
    .limit_i  (32'(TIMEOUT_CYCLES)),
    .expired_o(expired)
  );

  assign abort = expired;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign abort          = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    mem_addr_d  = mem_addr_q;
    mem_we_d    = mem_we_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_rvalid_d = 1'b0;
    d_rvalid_d  = 1'b0;
    err_d       = err_q;

    // Completion (normal or aborted) returns the response and frees the port.
    if (done || abort) begin
      state_d = StIdle;
      case (state_q)
        StBusyI: begin
          if_rvalid_d = 1'b1;
          if_rdata_d  = done ? bus_io.mem_rdata : DATA_W'(NopInstr);
        end
        StBusyD: begin
          d_rvalid_d = 1'b1;
          // Stores leave d_rdata untouched.
          if (!mem_we_q) begin
            d_rdata_d = done ? bus_io.mem_rdata : '0;
          end
        end
        default: ;
      endcase
    end

    if (abort) begin
      err_d = 1'b1;
    end

    // A grant in the completing cycle overrides the return to idle.
    if (gnt_d) begin
      state_d     = StBusyD;
      mem_addr_d  = bus_io.d_addr;
      mem_we_d    = bus_io.d_we;
      mem_wdata_d = bus_io.d_wdata;
    end else if (gnt_i) begin
      state_d    = StBusyI;
      mem_addr_d = bus_io.if_addr;
      mem_we_d   = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      if_rvalid_q <= if_rvalid_d;
      d_rvalid_q  <= d_rvalid_d;
      err_q       <= err_d;
    end
  end

  assign bus_io.if_gnt    = gnt_i;
  assign bus_io.d_gnt     = gnt_d;
  assign bus_io.if_rvalid = if_rvalid_q;
  assign bus_io.if_rdata  = if_rdata_q;
  assign bus_io.d_rvalid  = d_rvalid_q;
  assign bus_io.d_rdata   = d_rdata_q;
  assign bus_io.mem_req   = busy;
  assign bus_io.mem_we    = mem_we_q;
  assign bus_io.mem_addr  = mem_addr_q;
  assign bus_io.mem_wdata = mem_wdata_q;
  assign bus_io.stall     = (bus_io.if_req & ~gnt_i) | (bus_io.d_req & ~gnt_d);
  assign bus_io.err       = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed bench for mem_port_arbiter. A transaction-level model of the
// shared port (one outstanding access, data-first priority, response one cycle after the
// memory finishes) is checked against the DUT on every falling edge; the directed sequences
// add hand-computed literal expectations. Define MEM_TIMEOUT_EN to exercise the abort path.
module tb_mem_port_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
`ifdef MEM_TIMEOUT_EN
  localparam int unsigned ToCycles = 8;
`else
  localparam int unsigned ToCycles = 64;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_port_arbiter #(
    .ADDR_W        (AW),
    .DATA_W        (DW),
    .TIMEOUT_CYCLES(ToCycles)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus_io(bus)
  );

  // Memory: word i holds A000_0000+i, except 0x100 which holds DEADBEEF.
  logic [31:0] memarr [256];
  assign bus.mem_rdata = memarr[bus.mem_addr[9:2]];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Model state: at most one outstanding access plus the responses due this cycle.
  bit          m_busy, m_is_data, m_we, m_irv, m_drv, m_err;
  logic [31:0] m_addr, m_wdata, m_ird, m_drd;
  int unsigned m_wait;

  always @(negedge clk) begin
    bit slot, eg_d, eg_i, fin, abrt;
    if (!rst_n) begin
      check("rst_mem_req", bus.mem_req, 0);
      check("rst_mem_we", bus.mem_we, 0);
      check("rst_mem_addr", bus.mem_addr, 0);
      check("rst_mem_wdata", bus.mem_wdata, 0);
      check("rst_if_rvalid", bus.if_rvalid, 0);
      check("rst_d_rvalid", bus.d_rvalid, 0);
      check("rst_if_rdata", bus.if_rdata, 0);
      check("rst_d_rdata", bus.d_rdata, 0);
      check("rst_err", bus.err, 0);
      check("rst_gnt", {bus.if_gnt, bus.d_gnt}, 0);
      m_busy = 0; m_is_data = 0; m_we = 0; m_irv = 0; m_drv = 0; m_err = 0;
      m_addr = 0; m_wdata = 0; m_ird = 0; m_drd = 0; m_wait = 0;
    end else begin
      slot = !m_busy || bus.mem_ready;
      eg_d = slot && bus.d_req;
      eg_i = slot && bus.if_req && !bus.d_req;
      fin  = m_busy && bus.mem_ready;
`ifdef MEM_TIMEOUT_EN
      abrt = m_busy && !bus.mem_ready && (m_wait + 1 == ToCycles);
`else
      abrt = 0;
`endif
      check("m_d_gnt", bus.d_gnt, eg_d);
      check("m_if_gnt", bus.if_gnt, eg_i);
      check("m_stall", bus.stall, (bus.if_req && !eg_i) || (bus.d_req && !eg_d));
      check("m_mem_req", bus.mem_req, m_busy);
      if (m_busy) begin
        check("m_mem_addr", bus.mem_addr, m_addr);
        check("m_mem_we", bus.mem_we, m_we);
        if (m_we) check("m_mem_wdata", bus.mem_wdata, m_wdata);
      end
      check("m_if_rvalid", bus.if_rvalid, m_irv);
      check("m_d_rvalid", bus.d_rvalid, m_drv);
      check("m_if_rdata", bus.if_rdata, m_ird);
      check("m_d_rdata", bus.d_rdata, m_drd);
      check("m_err", bus.err, m_err);

      // Advance to the next cycle.
      m_irv = 0;
      m_drv = 0;
      if (fin || abrt) begin
        if (!m_is_data) begin
          m_irv = 1;
          m_ird = fin ? memarr[m_addr[9:2]] : 32'h0000_0013;
        end else begin
          m_drv = 1;
          if (!m_we) m_drd = fin ? memarr[m_addr[9:2]] : 32'h0;
        end
        m_busy = 0;
      end
      if (abrt) m_err = 1;
      if (m_busy && !bus.mem_ready) m_wait++;
      if (eg_d) begin
        m_busy = 1; m_is_data = 1; m_addr = bus.d_addr; m_we = bus.d_we;
        m_wdata = bus.d_wdata; m_wait = 0;
      end else if (eg_i) begin
        m_busy = 1; m_is_data = 0; m_addr = bus.if_addr; m_we = 0; m_wait = 0;
      end
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) memarr[i] = 32'hA000_0000 + i;
    memarr[64] = 32'hDEAD_BEEF;
    bus.if_req = 0; bus.if_addr = 0; bus.d_req = 0; bus.d_we = 0;
    bus.d_addr = 0; bus.d_wdata = 0; bus.mem_ready = 1;
    rst_n = 0;
    repeat (3) step();
    rst_n = 1;
    step();

    // Fetch stream 0x0, 0x4, 0x8 with mem_ready tied high.
    bus.if_req = 1; bus.if_addr = 32'h0;
    @(negedge clk); check("t1_gnt", bus.if_gnt, 1); check("t1_stall", bus.stall, 0);
    step(); bus.if_addr = 32'h4;
    step(); bus.if_addr = 32'h8;
    @(negedge clk); check("t1_rdata0", bus.if_rdata, 32'hA000_0000);
    check("t1_rvalid0", bus.if_rvalid, 1);
    step(); bus.if_req = 0;
    @(negedge clk); check("t1_rdata1", bus.if_rdata, 32'hA000_0001);
    step();
    @(negedge clk); check("t1_rdata2", bus.if_rdata, 32'hA000_0002);
    step();

    // Simultaneous requests: data first, fetch in the next slot.
    bus.if_req = 1; bus.if_addr = 32'hC; bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h100;
    @(negedge clk); check("t2_d_gnt", bus.d_gnt, 1); check("t2_if_gnt0", bus.if_gnt, 0);
    check("t2_stall", bus.stall, 1);
    step(); bus.d_req = 0;
    @(negedge clk); check("t2_if_gnt1", bus.if_gnt, 1); check("t2_stall_off", bus.stall, 0);
    step(); bus.if_req = 0;
    @(negedge clk); check("t2_d_rvalid", bus.d_rvalid, 1);
    check("t2_d_rdata", bus.d_rdata, 32'hDEAD_BEEF);
    step();
    @(negedge clk); check("t2_if_rdata", bus.if_rdata, 32'hA000_0003);
    step();

    // Store with mem_ready delayed 3 cycles; requester changes its bus after the grant.
    bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h20; bus.d_wdata = 32'h1234_5678;
    bus.mem_ready = 0;
    @(negedge clk); check("t3_d_gnt", bus.d_gnt, 1);
    step(); bus.d_req = 0; bus.d_we = 0; bus.d_addr = 32'h44; bus.d_wdata = 32'h0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) bus.mem_ready = 1;
      @(negedge clk);
      check("t3_mem_we", bus.mem_we, 1);
      check("t3_mem_addr", bus.mem_addr, 32'h20);
      check("t3_mem_wdata", bus.mem_wdata, 32'h1234_5678);
      check("t3_d_rvalid_early", bus.d_rvalid, 0);
      step();
    end
    @(negedge clk); check("t3_d_rvalid", bus.d_rvalid, 1);
    check("t3_d_rdata_kept", bus.d_rdata, 32'hDEAD_BEEF);
    step();

    // Reset during a stalled load.
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h100; bus.mem_ready = 0;
    @(negedge clk); check("t4_d_gnt", bus.d_gnt, 1);
    step(); bus.d_req = 0;
    @(negedge clk); check("t4_busy", bus.mem_req, 1);
    #2 rst_n = 0;
    #1 check("t4_req_drop", bus.mem_req, 0);
    bus.mem_ready = 1;
    step(); step();
    rst_n = 1; bus.if_req = 1; bus.if_addr = 32'h10;
    @(negedge clk); check("t4_if_gnt", bus.if_gnt, 1); check("t4_no_rvalid", bus.d_rvalid, 0);
    step(); bus.if_req = 0;
    step();
    @(negedge clk); check("t4_if_rvalid", bus.if_rvalid, 1);
    check("t4_if_rdata", bus.if_rdata, 32'hA000_0004);
    step();

`ifdef MEM_TIMEOUT_EN
    // Fetch that never completes: abort after ToCycles busy cycles.
    bus.if_req = 1; bus.if_addr = 32'h14; bus.mem_ready = 0;
    @(negedge clk); check("t5_gnt", bus.if_gnt, 1);
    step(); bus.if_req = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); check("t5_busy", bus.mem_req, 1);
      step();
    end
    @(negedge clk); check("t5_req_drop", bus.mem_req, 0);
    check("t5_if_rvalid", bus.if_rvalid, 1);
    check("t5_nop", bus.if_rdata, 32'h0000_0013);
    check("t5_err", bus.err, 1);
    step();
    // Stalled load: aborted with zero data.
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h100;
    @(negedge clk); check("t5_d_gnt", bus.d_gnt, 1);
    step(); bus.d_req = 0;
    repeat (8) step();
    @(negedge clk); check("t5_d_rvalid", bus.d_rvalid, 1);
    check("t5_d_zero", bus.d_rdata, 32'h0);
    check("t5_err_held", bus.err, 1);
    step();
    rst_n = 0;
    @(negedge clk); check("t5_err_clear", bus.err, 0);
    step(); rst_n = 1;
    bus.mem_ready = 1;
    step();
`else
    // Fetch that never completes: the arbiter waits indefinitely.
    bus.if_req = 1; bus.if_addr = 32'h14; bus.mem_ready = 0;
    @(negedge clk); check("t5_gnt", bus.if_gnt, 1);
    step();
    for (int i = 0; i < 200; i++) step();
    @(negedge clk); check("t5_req_held", bus.mem_req, 1);
    check("t5_err", bus.err, 0);
    check("t5_stall", bus.stall, 1);
    check("t5_no_gnt", bus.if_gnt, 0);
    step(); bus.mem_ready = 1;
    @(negedge clk); check("t5_regnt", bus.if_gnt, 1);
    step(); bus.if_req = 0;
    @(negedge clk); check("t5_rdata", bus.if_rdata, 32'hA000_0005);
    step(); step();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
